pluse_sync_sched: RTL and testbench

//  Source-domain scheduler that shares one toggle-based pulse synchronizer between
//  N_REQ event requesters. Queues one pending event per requester and grants them

---
 rtl/pluse_sync_sched_if.sv | 30 +++
 rtl/pluse_sync_sched.sv | 138 +++++++++++++
 tb/tb_pluse_sync_sched.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pluse_sync_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : pluse_sync_sched_if
// Function : Request/status bundle between requesters and the pulse scheduler.
// Revision : 1.0
// ============================================================================
interface pluse_sync_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic             en;
    logic [N_REQ-1:0] req;
    logic             ovf_clr;
    logic             s_pluse;
    logic [ID_W-1:0]  s_id;
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] ovf;
    logic             busy;

    modport master (
        output en, req, ovf_clr,
        input  s_pluse, s_id, pend, ovf, busy
    );

    modport slave (
        input  en, req, ovf_clr,
        output s_pluse, s_id, pend, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/pluse_sync_sched.sv
`default_nettype none
// ============================================================================
// Module   : pluse_sync_sched
// Function : Round-robin scheduler sharing one toggle pulse synchronizer
//            between N_REQ requesters, with a GAP-cycle minimum pulse spacing.
// Revision : 1.0
// ============================================================================
module pluse_sync_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int GAP   = 6
) (
    input  wire logic          src_clk,
    input  wire logic          src_rst,
    pluse_sync_sched_if.slave  bus
);
    localparam int              CNT_W      = $clog2(GAP) + 1;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [ID_W-1:0]  c_ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_rr_ptr_nxt;
    logic [ID_W-1:0]    r_s_id;
    logic [ID_W-1:0]    w_s_id_nxt;
    logic               r_s_pluse;
    logic               w_s_pluse_nxt;
    logic [N_REQ-1:0]   r_pend;
    logic [N_REQ-1:0]   w_pend_nxt;
    logic [N_REQ-1:0]   r_ovf;
    logic [N_REQ-1:0]   w_ovf_nxt;
    logic [N_REQ-1:0]   w_grant_vec;
    logic               w_grant;
    logic [ID_W-1:0]    w_win;
    logic               w_win_vld;
    int                 w_dist;
    int                 w_best;

    // Winner is the pending requester at the smallest upward distance from rr_ptr.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        w_best    = N_REQ;
        w_dist    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = i - int'(r_rr_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + N_REQ;
            end
            if (r_pend[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_win     = ID_W'(i);
                w_win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_s_pluse_nxt = 1'b0;
        w_s_id_nxt    = r_s_id;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_grant       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en && w_win_vld) begin
                    w_grant       = 1'b1;
                    w_s_pluse_nxt = 1'b1;
                    w_s_id_nxt    = w_win;
                    w_cnt_nxt     = c_CNT_LOAD;
                    w_state_nxt   = ST_GAP;
                    w_rr_ptr_nxt  = (w_win == c_ID_LAST) ? '0 : w_win + ID_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant_vec
            assign w_grant_vec[gi] = w_grant && (w_win == ID_W'(gi));
        end
    endgenerate

    // A request on its own grant edge re-arms pend; a set of ovf beats the clear.
    always_comb begin
        w_pend_nxt = (r_pend & ~w_grant_vec) | bus.req;
        w_ovf_nxt  = (r_ovf & ~{N_REQ{bus.ovf_clr}})
                   | (bus.req & r_pend & ~w_grant_vec);
    end

    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rr_ptr  <= '0;
            r_s_id    <= '0;
            r_s_pluse <= 1'b0;
            r_pend    <= '0;
            r_ovf     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_s_id    <= w_s_id_nxt;
            r_s_pluse <= w_s_pluse_nxt;
            r_pend    <= w_pend_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign bus.s_pluse = r_s_pluse;
    assign bus.s_id    = r_s_id;
    assign bus.pend    = r_pend;
    assign bus.ovf     = r_ovf;
    assign bus.busy    = (r_state == ST_GAP);

endmodule
`default_nettype wire

// File: tb/tb_pluse_sync_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pluse_sync_sched
// Function : Directed plus randomized bench against an event-level model.
// Revision : 1.0
// ============================================================================
module tb_pluse_sync_sched;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int GAP = 6;

    logic src_clk;
    logic src_rst;
    int   n_chk;
    int   n_err;

    pluse_sync_sched_if #(.N_REQ(N), .ID_W(IDW)) u_if ();

    pluse_sync_sched #(.N_REQ(N), .ID_W(IDW), .GAP(GAP)) u_dut (
        .src_clk (src_clk),
        .src_rst (src_rst),
        .bus     (u_if.slave)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    // Model state: outputs plus the edge index of the last grant.
    logic [N-1:0]   m_pend;
    logic [N-1:0]   m_ovf;
    logic           m_pl;
    logic [IDW-1:0] m_id;
    logic           m_busy;
    int             m_rr;
    int             m_edge;
    int             m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        chk("s_pluse", 32'(u_if.s_pluse), 32'(m_pl));
        chk("s_id",    32'(u_if.s_id),    32'(m_id));
        chk("pend",    32'(u_if.pend),    32'(m_pend));
        chk("ovf",     32'(u_if.ovf),     32'(m_ovf));
        chk("busy",    32'(u_if.busy),    32'(m_busy));
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_ovf  = '0;
        m_pl   = 1'b0;
        m_id   = '0;
        m_busy = 1'b0;
        m_rr   = 0;
        m_last = -1000;
    endtask

    // One clock edge of the scheduler, from the event-level rules.
    task automatic model_edge(input logic en_v, input logic [N-1:0] req_v, input logic clr_v);
        int w;
        logic [N-1:0] np;
        logic [N-1:0] no;
        w = -1;
        if (en_v && (m_pend != '0) && (m_edge - m_last >= GAP)) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (w < 0 && m_pend[idx]) w = idx;
            end
        end
        np = m_pend;
        no = m_ovf;
        for (int i = 0; i < N; i++) begin
            if (clr_v) no[i] = 1'b0;
            if (req_v[i] && m_pend[i] && (w != i)) no[i] = 1'b1;
            if (w == i) np[i] = 1'b0;
            if (req_v[i]) np[i] = 1'b1;
        end
        m_pend = np;
        m_ovf  = no;
        m_pl   = (w >= 0);
        if (w >= 0) begin
            m_id   = IDW'(w);
            m_rr   = (w + 1) % N;
            m_last = m_edge;
        end
        m_busy = (m_edge - m_last) <= (GAP - 2);
        m_edge++;
    endtask

    task automatic step(input logic en_v, input logic [N-1:0] req_v, input logic clr_v);
        u_if.en      = en_v;
        u_if.req     = req_v;
        u_if.ovf_clr = clr_v;
        @(posedge src_clk);
        model_edge(en_v, req_v, clr_v);
        #1;
        check_all();
    endtask

    task automatic reset_pulse(input int cycles);
        u_if.req     = '0;
        u_if.ovf_clr = 1'b0;
        src_rst      = 1'b1;
        #2;
        model_reset();
        check_all();
        repeat (cycles) begin
            @(posedge src_clk);
            m_edge++;
            #1;
            check_all();
        end
        src_rst = 1'b0;
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        m_edge       = 0;
        src_rst      = 1'b0;
        u_if.en      = 1'b0;
        u_if.req     = '0;
        u_if.ovf_clr = 1'b0;
        model_reset();
        reset_pulse(2);

        // Single request from requester 0.
        step(1'b1, 4'b0001, 1'b0);
        repeat (8) step(1'b1, 4'b0000, 1'b0);

        // All four requesters at once: four spaced pulses in index order.
        step(1'b1, 4'b1111, 1'b0);
        repeat (24) step(1'b1, 4'b0000, 1'b0);

        // Continuous requester 2 load, then overflow clear.
        repeat (30) step(1'b1, 4'b0100, 1'b0);
        repeat (6) step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b0);

        // Wrap-around order 3 then 1, with req[1] on its own grant edge.
        reset_pulse(1);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1010, 1'b0);
        repeat (10) step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        repeat (14) step(1'b1, 4'b0000, 1'b0);

        // Issue hold while disabled.
        reset_pulse(1);
        step(1'b0, 4'b0110, 1'b0);
        repeat (5) step(1'b0, 4'b0000, 1'b0);
        repeat (14) step(1'b1, 4'b0000, 1'b0);

        // Asynchronous reset in the middle of a gap with events pending.
        reset_pulse(1);
        step(1'b1, 4'b1100, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        reset_pulse(1);
        repeat (10) step(1'b1, 4'b0000, 1'b0);

        // Randomized traffic with varying load.
        for (int c = 0; c < 800; c++) begin
            logic [N-1:0] r;
            int lim;
            lim = (c < 400) ? 5 : 1;
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(lim) == 0);
            if ($urandom_range(299) == 0) begin
                reset_pulse(1);
            end else begin
                step(($urandom_range(7) != 0), r, ($urandom_range(15) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
